// File: rtl/game_multi_target_fsm_if.sv
// Controller <-> sprite/mixer bundle for the multi-target game.
// master = game controller, slave = sprite engines and mixer.
interface game_multi_target_fsm_if #(
  parameter int N_TARGETS = 4,
  parameter int SCORE_W   = 8,
  parameter int LIVES_W   = 2
);
  logic                 launch_key;
  logic [N_TARGETS-1:0] target_within_screen;
  logic                 torpedo_within_screen;
  logic [N_TARGETS-1:0] collision;
  logic [N_TARGETS-1:0] target_write_xy;
  logic [N_TARGETS-1:0] target_write_dxy;
  logic [N_TARGETS-1:0] target_enable_update;
  logic                 torpedo_write_xy;
  logic                 torpedo_write_dxy;
  logic                 torpedo_enable_update;
  logic [N_TARGETS-1:0] target_alive;
  logic [SCORE_W-1:0]   score;
  logic [LIVES_W-1:0]   lives;
  logic                 game_won;
  logic                 game_lost;
  logic                 end_of_game_timer_running;

  modport master (
    input  launch_key, target_within_screen, torpedo_within_screen, collision,
    output target_write_xy, target_write_dxy, target_enable_update,
           torpedo_write_xy, torpedo_write_dxy, torpedo_enable_update,
           target_alive, score, lives, game_won, game_lost, end_of_game_timer_running
  );

  modport slave (
    output launch_key, target_within_screen, torpedo_within_screen, collision,
    input  target_write_xy, target_write_dxy, target_enable_update,
           torpedo_write_xy, torpedo_write_dxy, torpedo_enable_update,
           target_alive, score, lives, game_won, game_lost, end_of_game_timer_running
  );
endinterface

// File: rtl/game_multi_target_fsm.sv
// Multi-target game master FSM: spawn/aim/shoot/end with alive mask, score, lives, end timer.
// All outputs registered (one cycle after the causing state/condition); no backpressure.
module game_multi_target_fsm #(
  parameter int                     N_TARGETS       = 4,
  parameter int                     SCORE_W         = 8,
  parameter int                     LIVES           = 3,
  parameter int                     LIVES_W         = 2,
  parameter int                     END_TIMER_W     = 25,
  parameter logic [END_TIMER_W-1:0] END_TIMER_VALUE = 25'h1000000
) (
  input  logic clk,
  input  logic rst,
  game_multi_target_fsm_if.master bus
);
  localparam int SUM_W = SCORE_W + 5;

  typedef enum logic [2:0] {IDLE, START, AIM, SHOOT, END_S} state_t;

  state_t                   state, state_n;
  logic                     launch_q, launch_rise;
  logic                     new_game, new_game_n;
  logic [N_TARGETS-1:0]     hits, alive_n, txy_n, ten_n, tvis;
  logic                     pxy_n, pen_n, pvis, active;
  logic [4:0]               hit_cnt;
  logic [SUM_W-1:0]         score_sum;
  logic [SCORE_W-1:0]       score_n;
  logic [LIVES_W-1:0]       lives_n;
  logic                     won_n, lost_n, run_n;
  logic [END_TIMER_W-1:0]   timer, timer_n;
  logic [N_TARGETS-1:0][1:0] tguard, tguard_n;
  logic [1:0]               pguard, pguard_n;

  always_comb begin
    launch_rise = bus.launch_key & ~launch_q;
    hits        = bus.collision & bus.target_alive;
    hit_cnt     = '0;
    for (int i = 0; i < N_TARGETS; i++) begin
      hit_cnt = hit_cnt + 5'(hits[i]);
      // A freshly loaded sprite counts as on-screen until its guard expires.
      tvis[i] = bus.target_within_screen[i] | (tguard[i] != 2'd0);
    end
    pvis      = bus.torpedo_within_screen | (pguard != 2'd0);
    score_sum = SUM_W'(bus.score) + SUM_W'(hit_cnt);

    state_n    = state;
    alive_n    = bus.target_alive;
    score_n    = bus.score;
    lives_n    = bus.lives;
    won_n      = bus.game_won;
    lost_n     = bus.game_lost;
    new_game_n = new_game;
    timer_n    = timer;
    txy_n      = '0;
    pxy_n      = 1'b0;

    case (state)
      IDLE: state_n = START;
      START: begin
        txy_n      = '1;
        pxy_n      = 1'b1;
        alive_n    = '1;
        won_n      = 1'b0;
        lost_n     = 1'b0;
        new_game_n = 1'b0;
        if (new_game) begin
          score_n = '0;
          lives_n = LIVES_W'(LIVES);
        end
        state_n = AIM;
      end
      AIM: if (launch_rise) state_n = SHOOT;
      SHOOT: begin
        if (hits != '0) begin
          alive_n = bus.target_alive & ~hits;
          score_n = (score_sum[SUM_W-1:SCORE_W] != '0) ? '1 : score_sum[SCORE_W-1:0];
          pxy_n   = 1'b1;
          if (alive_n == '0) begin
            state_n = END_S;
            won_n   = 1'b1;
          end else begin
            state_n = AIM;
          end
        end else if (!pvis) begin
          lives_n = bus.lives - 1'b1;
          pxy_n   = 1'b1;
          if (bus.lives <= LIVES_W'(1)) begin
            state_n    = END_S;
            lost_n     = 1'b1;
            new_game_n = 1'b1;
          end else begin
            state_n = AIM;
          end
        end
      end
      END_S: begin
        if (timer != '0) timer_n = timer - 1'b1;
        if (timer <= END_TIMER_W'(1)) state_n = START;
      end
      default: state_n = IDLE;
    endcase

    if (state_n == END_S && state != END_S) timer_n = END_TIMER_VALUE;

    active = (state == AIM || state == SHOOT) && (state_n == AIM || state_n == SHOOT);
    if (active) txy_n = txy_n | (alive_n & ~tvis);
    ten_n = active ? alive_n : '0;
    pen_n = (state == SHOOT) && (state_n == SHOOT);
    run_n = (state_n == END_S) && (timer_n != '0);

    for (int i = 0; i < N_TARGETS; i++)
      tguard_n[i] = txy_n[i] ? 2'd3 : ((tguard[i] != 2'd0) ? tguard[i] - 2'd1 : 2'd0);
    pguard_n = pxy_n ? 2'd3 : ((pguard != 2'd0) ? pguard - 2'd1 : 2'd0);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state                         <= IDLE;
      launch_q                      <= 1'b0;
      new_game                      <= 1'b1;
      timer                         <= '0;
      tguard                        <= '0;
      pguard                        <= 2'd0;
      bus.target_write_xy           <= '0;
      bus.target_write_dxy          <= '0;
      bus.target_enable_update      <= '0;
      bus.torpedo_write_xy          <= 1'b0;
      bus.torpedo_write_dxy         <= 1'b0;
      bus.torpedo_enable_update     <= 1'b0;
      bus.target_alive              <= '0;
      bus.score                     <= '0;
      bus.lives                     <= LIVES_W'(LIVES);
      bus.game_won                  <= 1'b0;
      bus.game_lost                 <= 1'b0;
      bus.end_of_game_timer_running <= 1'b0;
    end else begin
      state                         <= state_n;
      launch_q                      <= bus.launch_key;
      new_game                      <= new_game_n;
      timer                         <= timer_n;
      tguard                        <= tguard_n;
      pguard                        <= pguard_n;
      bus.target_write_xy           <= txy_n;
      bus.target_write_dxy          <= txy_n;
      bus.target_enable_update      <= ten_n;
      bus.torpedo_write_xy          <= pxy_n;
      bus.torpedo_write_dxy         <= pxy_n;
      bus.torpedo_enable_update     <= pen_n;
      bus.target_alive              <= alive_n;
      bus.score                     <= score_n;
      bus.lives                     <= lives_n;
      bus.game_won                  <= won_n;
      bus.game_lost                 <= lost_n;
      bus.end_of_game_timer_running <= run_n;
    end
  end
endmodule

// File: tb/tb_game_multi_target_fsm.sv
// Directed bench: per-cycle vector table for spawn/aim/shoot/respawn, then hand sequences for END.
module tb_game_multi_target_fsm;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   pass_cnt = 0;
  int   total_cnt = 0;

  always #5 clk = ~clk;

  game_multi_target_fsm_if #(.N_TARGETS(4), .SCORE_W(8), .LIVES_W(2)) vif ();

  game_multi_target_fsm #(
    .N_TARGETS(4), .SCORE_W(8), .LIVES(3), .LIVES_W(2),
    .END_TIMER_W(25), .END_TIMER_VALUE(25'd16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(vif)
  );

  typedef struct {
    logic       l;
    logic [3:0] tws;
    logic       tps;
    logic [3:0] coll;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[25];

  function automatic logic [31:0] pk(logic [3:0] txy, logic [3:0] tdxy, logic [3:0] ten,
                                     logic pxy, logic pdxy, logic pen, logic [3:0] alive,
                                     logic [7:0] score, logic [1:0] lives,
                                     logic won, logic lost, logic run);
    return {txy, tdxy, ten, pxy, pdxy, pen, alive, score, lives, won, lost, run};
  endfunction

  function automatic vec_t v(logic l, logic [3:0] tws, logic tps, logic [3:0] coll,
                             logic [3:0] txy, logic [3:0] ten, logic pxy, logic pen,
                             logic [3:0] alive, logic [7:0] score);
    vec_t r;
    r.l = l; r.tws = tws; r.tps = tps; r.coll = coll;
    r.exp = pk(txy, txy, ten, pxy, pxy, pen, alive, score, 2'd3, 1'b0, 1'b0, 1'b0);
    return r;
  endfunction

  function automatic logic [31:0] actual();
    return pk(vif.target_write_xy, vif.target_write_dxy, vif.target_enable_update,
              vif.torpedo_write_xy, vif.torpedo_write_dxy, vif.torpedo_enable_update,
              vif.target_alive, vif.score, vif.lives, vif.game_won, vif.game_lost,
              vif.end_of_game_timer_running);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic l, input logic [3:0] tws, input logic tps, input logic [3:0] coll);
    vif.launch_key            = l;
    vif.target_within_screen  = tws;
    vif.torpedo_within_screen = tps;
    vif.collision             = coll;
  endtask

  task automatic wait_end(output int cyc);
    cyc = 0;
    while (vif.end_of_game_timer_running === 1'b1 && cyc < 100) begin
      tick();
      cyc++;
    end
  endtask

  task automatic miss();
    drive(1'b1, 4'hF, 1'b1, 4'h0); tick();
    drive(1'b0, 4'hF, 1'b1, 4'h0); tick();
    tick();
    drive(1'b0, 4'hF, 1'b0, 4'h0); tick();
    drive(1'b0, 4'hF, 1'b1, 4'h0);
  endtask

  task automatic shoot(input logic [3:0] coll);
    drive(1'b1, 4'hF, 1'b1, 4'h0); tick();
    drive(1'b0, 4'hF, 1'b1, coll); tick();
    drive(1'b0, 4'hF, 1'b1, 4'h0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int cyc;
    int bad;
    vecs[0]  = v(0, 4'hF, 1, 4'h0, 4'h0, 4'h0, 0, 0, 4'h0, 8'd0);
    vecs[1]  = v(0, 4'hF, 1, 4'h0, 4'hF, 4'h0, 1, 0, 4'hF, 8'd0);
    vecs[2]  = v(0, 4'hF, 1, 4'h0, 4'h0, 4'hF, 0, 0, 4'hF, 8'd0);
    vecs[3]  = v(1, 4'hF, 1, 4'h0, 4'h0, 4'hF, 0, 0, 4'hF, 8'd0);
    for (int i = 4; i < 13; i++)
      vecs[i] = v(1, 4'hF, 1, 4'h0, 4'h0, 4'hF, 0, 1, 4'hF, 8'd0);
    vecs[13] = v(1, 4'hF, 1, 4'h5, 4'h0, 4'hA, 1, 0, 4'hA, 8'd2);
    vecs[14] = v(1, 4'hF, 1, 4'hF, 4'h0, 4'hA, 0, 0, 4'hA, 8'd2);
    vecs[15] = v(0, 4'hF, 1, 4'h0, 4'h0, 4'hA, 0, 0, 4'hA, 8'd2);
    vecs[16] = v(1, 4'hF, 1, 4'h0, 4'h0, 4'hA, 0, 0, 4'hA, 8'd2);
    vecs[17] = v(1, 4'hF, 1, 4'h0, 4'h0, 4'hA, 0, 1, 4'hA, 8'd2);
    // Hit and miss together: hit wins, lives stay at 3.
    vecs[18] = v(1, 4'hF, 0, 4'h2, 4'h0, 4'h8, 1, 0, 4'h8, 8'd3);
    vecs[19] = v(0, 4'h6, 1, 4'h0, 4'h8, 4'h8, 0, 0, 4'h8, 8'd3);
    vecs[20] = v(0, 4'h6, 1, 4'h0, 4'h0, 4'h8, 0, 0, 4'h8, 8'd3);
    vecs[21] = v(0, 4'h6, 1, 4'h0, 4'h0, 4'h8, 0, 0, 4'h8, 8'd3);
    vecs[22] = v(0, 4'h6, 1, 4'h0, 4'h0, 4'h8, 0, 0, 4'h8, 8'd3);
    vecs[23] = v(0, 4'h6, 1, 4'h0, 4'h8, 4'h8, 0, 0, 4'h8, 8'd3);
    vecs[24] = v(0, 4'hF, 1, 4'h0, 4'h0, 4'h8, 0, 0, 4'h8, 8'd3);

    drive(1'b0, 4'hF, 1'b1, 4'h0);
    #23;
    check("reset_state", actual(), pk(0, 0, 0, 0, 0, 0, 0, 8'd0, 2'd3, 0, 0, 0));
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 25; i++) begin
      drive(vecs[i].l, vecs[i].tws, vecs[i].tps, vecs[i].coll);
      tick();
      check($sformatf("vec%0d", i), actual(), vecs[i].exp);
    end

    // Three misses end the game as lost.
    miss();
    check("miss1_lives_reload", {30'd0, vif.lives, vif.torpedo_write_xy}, {30'd0, 2'd2, 1'b1});
    miss();
    check("miss2_lives", {30'd0, vif.lives}, {30'd0, 2'd1});
    miss();
    check("miss3_end_lost",
          {25'd0, vif.lives, vif.game_lost, vif.end_of_game_timer_running,
           vif.target_enable_update, vif.torpedo_enable_update},
          {25'd0, 2'd0, 1'b1, 1'b1, 4'h0, 1'b0});
    wait_end(cyc);
    check("lost_timer_cycles", 32'(cyc), 32'd16);
    tick();
    check("restart_after_loss", actual(), pk(4'hF, 4'hF, 0, 1, 1, 0, 4'hF, 8'd0, 2'd3, 0, 0, 0));

    // Win games by clearing all targets to push the score up.
    shoot(4'hF);
    check("win1", {22'd0, vif.game_won, vif.end_of_game_timer_running, vif.score},
          {22'd0, 1'b1, 1'b1, 8'd4});
    wait_end(cyc);
    bad = (cyc == 16) ? 0 : 1;
    tick();
    for (int g = 1; g < 63; g++) begin
      shoot(4'hF);
      wait_end(cyc);
      if (cyc != 16) bad++;
      tick();
    end
    check("win_timer_all_games", 32'(bad), 32'd0);
    check("score_252", {24'd0, vif.score}, {24'd0, 8'd252});
    shoot(4'h3);
    check("partial_hit_254", {20'd0, vif.score, vif.target_alive}, {20'd0, 8'd254, 4'hC});
    shoot(4'hC);
    check("saturate_win",
          {21'd0, vif.score, vif.game_won, vif.game_lost, vif.end_of_game_timer_running},
          {21'd0, 8'hFF, 1'b1, 1'b0, 1'b1});
    wait_end(cyc);
    tick();
    check("restart_after_win", actual(), pk(4'hF, 4'hF, 0, 1, 1, 0, 4'hF, 8'hFF, 2'd3, 0, 0, 0));

    // Asynchronous reset mid-game.
    tick();
    #2 rst = 1'b0;
    #1;
    check("async_reset", actual(), pk(0, 0, 0, 0, 0, 0, 0, 8'd0, 2'd3, 0, 0, 0));
    #20 rst = 1'b1;

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
